// File: rtl/sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweeper_pkg
// Description : Shared types and constants for the truth-table sweeper:
//               FSM state enumeration, number of input combinations and
//               table/stimulus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEP_E1 = 2'd1,
    SWEEP_E0 = 2'd2,
    FIN      = 2'd3
  } sweep_state_t;

  localparam int NUM_COMB = 16;        // input combinations of a 4-input function
  localparam int TT_WIDTH = NUM_COMB;  // one table bit per combination
  localparam int ABCD_W   = 4;
  localparam int DWELL_W  = 8;         // holds DWELL up to 255

  // True in the two states where stimulus is being applied and sampled.
  function automatic logic is_sweeping(input sweep_state_t s);
    return (s == SWEEP_E1) || (s == SWEEP_E0);
  endfunction

endpackage : sweeper_pkg
`default_nettype wire

// File: rtl/sweep_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : sweep_dwell_counter
// Description : Counts 0..DWELL-1 while run is high and flags the final
//               settle cycle of each dwell period. Returns to 0 whenever run
//               is low, so every sweep starts from a clean count.
// Ports       : clk   - clock
//               rst   - asynchronous active-high reset
//               run   - count enable (high during a sweep)
//               count - current dwell count
//               last  - high on the cycle count equals DWELL-1 while running
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_dwell_counter
  import sweeper_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [DWELL_W-1:0] count,
  output logic               last
);

  localparam logic [DWELL_W-1:0] c_last = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] r_count;
  logic               w_last;

  // Combinational so that DWELL=1 yields a strobe on every running cycle.
  assign w_last = run && (r_count == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!run || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DWELL_W'(1);
    end
  end

  assign count = r_count;
  assign last  = w_last;

endmodule : sweep_dwell_counter
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives all 16 abcd combinations to an external 4-input
//               function, first with en=1 then with en=0, holding each value
//               DWELL cycles and capturing f_in on the last settle cycle into
//               two 16-bit truth tables. Flags err if the function responds
//               while disabled.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset
//               start  - request a sweep (only honoured in IDLE)
//               abcd   - stimulus, bit3=A .. bit0=D
//               en     - enable driven to the function under test
//               f_in   - function output returned from the function
//               busy   - sweep in progress
//               done   - one-cycle completion pulse
//               tt_en1 - table captured with en=1, bit i = F(abcd=i)
//               tt_en0 - table captured with en=0, bit i = F(abcd=i)
//               err    - sticky: a 1 was captured while en=0
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ABCD_W-1:0]   abcd,
  output logic                en,
  input  logic                f_in,
  output logic                busy,
  output logic                done,
  output logic [TT_WIDTH-1:0] tt_en1,
  output logic [TT_WIDTH-1:0] tt_en0,
  output logic                err
);

  localparam logic [ABCD_W-1:0] c_abcd_max = ABCD_W'(NUM_COMB - 1);

  sweep_state_t        r_state;
  logic [ABCD_W-1:0]   r_abcd;
  logic                r_en;
  logic                r_busy;
  logic                r_done;
  logic [TT_WIDTH-1:0] r_tt_en1;
  logic [TT_WIDTH-1:0] r_tt_en0;
  logic                r_err;

  logic                w_run;
  logic                w_last;
  logic [DWELL_W-1:0]  w_dwell_cnt;
  logic                w_unused;

  assign w_run = is_sweeping(r_state);

  sweep_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .run   (w_run),
    .count (w_dwell_cnt),
    .last  (w_last)
  );

  // The dwell count itself is only observed for debug; the FSM acts on the
  // last-cycle strobe.
  assign w_unused = ^w_dwell_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_abcd   <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tt_en1 <= '0;
      r_tt_en0 <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= SWEEP_E1;
            r_abcd   <= '0;
            r_en     <= 1'b1;
            r_busy   <= 1'b1;
            r_tt_en1 <= '0;
            r_tt_en0 <= '0;
            r_err    <= 1'b0;
          end
        end

        SWEEP_E1: begin
          if (w_last) begin
            r_tt_en1[r_abcd] <= f_in;
            if (r_abcd == c_abcd_max) begin
              // Enabled pass complete: repeat all combinations disabled.
              r_abcd  <= '0;
              r_en    <= 1'b0;
              r_state <= SWEEP_E0;
            end else begin
              r_abcd <= r_abcd + ABCD_W'(1);
            end
          end
        end

        SWEEP_E0: begin
          if (w_last) begin
            r_tt_en0[r_abcd] <= f_in;
            if (f_in) begin
              r_err <= 1'b1;
            end
            if (r_abcd == c_abcd_max) begin
              r_abcd  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_abcd <= r_abcd + ABCD_W'(1);
            end
          end
        end

        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_abcd  <= '0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign abcd   = r_abcd;
  assign en     = r_en;
  assign busy   = r_busy;
  assign done   = r_done;
  assign tt_en1 = r_tt_en1;
  assign tt_en0 = r_tt_en0;
  assign err    = r_err;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper. Two instances
//               (DWELL=10 and DWELL=1) share clock and reset. The function
//               under test is a pair of lookup tables (en=1 / en=0) so both
//               the reference function and random functions can be applied;
//               expected tables, timing and abcd sequence come from a
//               behavioural model of the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

  localparam int DW_A = 10;
  localparam int DW_B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st  = 1'b0;
  logic        sel_b = 1'b0;
  logic [15:0] tbl1 = 16'h0;
  logic [15:0] tbl0 = 16'h0;

  logic        start_a, start_b, f_in_a, f_in_b;
  logic [3:0]  abcd_a, abcd_b;
  logic        en_a, en_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [15:0] tt1_a, tt0_a, tt1_b, tt0_b;

  logic [3:0]  s_abcd;
  logic        s_en, s_busy, s_done, s_err;
  logic [15:0] s_tt1, s_tt0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign start_a = st & ~sel_b;
  assign start_b = st & sel_b;

  // External function under test.
  assign f_in_a = en_a ? tbl1[abcd_a] : tbl0[abcd_a];
  assign f_in_b = en_b ? tbl1[abcd_b] : tbl0[abcd_b];

  assign s_abcd = sel_b ? abcd_b : abcd_a;
  assign s_en   = sel_b ? en_b   : en_a;
  assign s_busy = sel_b ? busy_b : busy_a;
  assign s_done = sel_b ? done_b : done_a;
  assign s_err  = sel_b ? err_b  : err_a;
  assign s_tt1  = sel_b ? tt1_b  : tt1_a;
  assign s_tt0  = sel_b ? tt0_b  : tt0_a;

  truth_table_sweeper #(.DWELL(DW_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abcd(abcd_a), .en(en_a),
    .f_in(f_in_a), .busy(busy_a), .done(done_a), .tt_en1(tt1_a),
    .tt_en0(tt0_a), .err(err_a)
  );

  truth_table_sweeper #(.DWELL(DW_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abcd(abcd_b), .en(en_b),
    .f_in(f_in_b), .busy(busy_b), .done(done_b), .tt_en1(tt1_b),
    .tt_en0(tt0_b), .err(err_b)
  );

  // Reference function F = en & (A(CD+B) + BC').
  function automatic logic ref_f(input int idx, input logic e);
    logic a, b, c, d;
    a = idx[3]; b = idx[2]; c = idx[1]; d = idx[0];
    return e & ((a & ((c & d) | b)) | (b & ~c));
  endfunction

  function automatic logic [15:0] ref_table(input logic e);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = ref_f(i, e);
    return t;
  endfunction

  // Run one sweep on the selected instance and measure it. While busy, abcd
  // must equal (cycle/DWELL) mod 16 and en must be 1 for the first half.
  task automatic sweep(input logic b, input int repulse_at,
                       output int busy_cyc, output int done_cnt,
                       output int seq_bad, output int changes);
    int dw;
    int k;
    int post;
    logic [3:0] prev;
    dw = b ? DW_B : DW_A;
    k = 0; post = -1; busy_cyc = 0; done_cnt = 0; seq_bad = 0; changes = 0;
    prev = 4'h0;
    sel_b = b;
    @(negedge clk);
    st = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (s_busy) begin
        if (s_abcd !== 4'((k / dw) % 16)) seq_bad++;
        if (s_en !== ((k < 16 * dw) ? 1'b1 : 1'b0)) seq_bad++;
        if (k > 0 && s_abcd !== prev) changes++;
        prev = s_abcd;
        k++;
        busy_cyc++;
      end
      if (s_done) done_cnt++;
      st = (repulse_at >= 0 && k == repulse_at && s_busy) ? 1'b1 : 1'b0;
      if (done_cnt > 0) post++;
      if (post == 4) break;
    end
    st = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({abcd_a, en_a, busy_a, done_a, err_a, tt1_a, tt0_a} !== 40'h0) begin
      $display("FAIL reset_a: got abcd=%h en=%b busy=%b done=%b err=%b tt1=%h tt0=%h, want all 0",
               abcd_a, en_a, busy_a, done_a, err_a, tt1_a, tt0_a);
    end else n_pass++;
    n_checks++;
    if ({abcd_b, en_b, busy_b, done_b, err_b, tt1_b, tt0_b} !== 40'h0) begin
      $display("FAIL reset_b: got abcd=%h en=%b busy=%b done=%b err=%b tt1=%h tt0=%h, want all 0",
               abcd_b, en_b, busy_b, done_b, err_b, tt1_b, tt0_b);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full sweep with the reference function; repulse_at>=0 re-pulses start
  // mid-sweep, which must be ignored.
  task automatic test_ref_sweep(input logic b, input int repulse_at, input string tag);
    int bc, dc, sb, ch;
    int dw;
    dw = b ? DW_B : DW_A;
    tbl1 = ref_table(1'b1);
    tbl0 = ref_table(1'b0);
    sweep(b, repulse_at, bc, dc, sb, ch);
    n_checks++;
    if (bc !== 32 * dw) $display("FAIL %s busy_cycles: got %0d want %0d", tag, bc, 32 * dw);
    else n_pass++;
    n_checks++;
    if (dc !== 1) $display("FAIL %s done_pulses: got %0d want 1", tag, dc);
    else n_pass++;
    n_checks++;
    if (sb !== 0) $display("FAIL %s abcd_en_sequence: got %0d bad cycles want 0", tag, sb);
    else n_pass++;
    n_checks++;
    if (s_tt1 !== 16'hF830 || s_tt1 !== tbl1)
      $display("FAIL %s tt_en1: got %h want %h", tag, s_tt1, 16'hF830);
    else n_pass++;
    n_checks++;
    if (s_tt0 !== 16'h0000) $display("FAIL %s tt_en0: got %h want 0000", tag, s_tt0);
    else n_pass++;
    n_checks++;
    if (s_err !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL %s err_busy_after: got err=%b busy=%b want 0 0", tag, s_err, s_busy);
    else n_pass++;
    if (b) begin
      n_checks++;
      if (ch !== 31) $display("FAIL %s abcd_changes: got %0d want 31", tag, ch);
      else n_pass++;
    end
  endtask

  task automatic test_faulty;
    int bc, dc, sb, ch;
    tbl1 = 16'hFFFF;
    tbl0 = 16'hFFFF;
    sweep(1'b0, -1, bc, dc, sb, ch);
    n_checks++;
    if (tt1_a !== 16'hFFFF || tt0_a !== 16'hFFFF || err_a !== 1'b1)
      $display("FAIL faulty: got tt1=%h tt0=%h err=%b want FFFF FFFF 1", tt1_a, tt0_a, err_a);
    else n_pass++;
    // Results must hold while idle.
    repeat (5) @(negedge clk);
    n_checks++;
    if (tt1_a !== 16'hFFFF || tt0_a !== 16'hFFFF || err_a !== 1'b1 || done_a !== 1'b0)
      $display("FAIL faulty_hold: got tt1=%h tt0=%h err=%b done=%b want FFFF FFFF 1 0",
               tt1_a, tt0_a, err_a, done_a);
    else n_pass++;
  endtask

  task automatic test_random(input int iters);
    int bc, dc, sb, ch;
    logic b;
    logic [15:0] e1, e0;
    for (int it = 0; it < iters; it++) begin
      b  = 1'($urandom_range(0, 1));
      e1 = 16'($urandom);
      e0 = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      tbl1 = e1;
      tbl0 = e0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sweep(b, -1, bc, dc, sb, ch);
      n_checks++;
      if (s_tt1 !== e1 || s_tt0 !== e0 || s_err !== (e0 != 16'h0) || dc !== 1 || sb !== 0)
        $display("FAIL random_%0d: got tt1=%h tt0=%h err=%b done=%0d seqbad=%0d want %h %h %b 1 0",
                 it, s_tt1, s_tt0, s_err, dc, sb, e1, e0, (e0 != 16'h0));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int k;
    int seen;
    int bc, dc, sb, ch;
    logic [15:0] e1;
    tbl1 = ref_table(1'b1);
    tbl0 = 16'h0;
    sel_b = 1'b0;
    k = 0;
    @(negedge clk);
    st = 1'b1;
    for (int c = 0; c < 1000 && k < 200; c++) begin
      @(negedge clk);
      st = 1'b0;
      if (busy_a) k++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({abcd_a, en_a, busy_a, done_a, err_a, tt1_a, tt0_a} !== 40'h0 || k != 200)
      $display("FAIL reset_mid: got abcd=%h en=%b busy=%b done=%b tt1=%h busy_cycles=%0d want 0s at 200",
               abcd_a, en_a, busy_a, done_a, tt1_a, k);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_quiet: got %0d busy/done cycles want 0", seen);
    else n_pass++;
    e1 = 16'($urandom);
    tbl1 = e1;
    sweep(1'b0, -1, bc, dc, sb, ch);
    n_checks++;
    if (tt1_a !== e1 || tt0_a !== 16'h0 || dc !== 1 || bc !== 32 * DW_A)
      $display("FAIL reset_mid_resweep: got tt1=%h tt0=%h done=%0d busy=%0d want %h 0000 1 %0d",
               tt1_a, tt0_a, dc, bc, e1, 32 * DW_A);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int gap;
    logic got;
    tbl1 = ref_table(1'b1);
    tbl0 = 16'h0;
    sel_b = 1'b0;
    @(negedge clk);
    st = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      got = done_a;
    end
    n_checks++;
    if (!got || tt1_a !== 16'hF830)
      $display("FAIL b2b_first: got done=%b tt1=%h want 1 F830", got, tt1_a);
    else n_pass++;
    gap = 0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      gap++;
      got = busy_a;
    end
    st = 1'b0;
    n_checks++;
    if (!got || gap !== 2 || tt1_a !== 16'h0 || tt0_a !== 16'h0)
      $display("FAIL b2b_restart: got busy=%b gap=%0d tt1=%h tt0=%h want 1 2 0000 0000",
               got, gap, tt1_a, tt0_a);
    else n_pass++;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      got = done_a;
    end
    n_checks++;
    if (!got || tt1_a !== 16'hF830 || tt0_a !== 16'h0 || err_a !== 1'b0)
      $display("FAIL b2b_second: got done=%b tt1=%h tt0=%h err=%b want 1 F830 0000 0",
               got, tt1_a, tt0_a, err_a);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ref_sweep(1'b0, -1, "dwell10");
    test_ref_sweep(1'b1, -1, "dwell1");
    test_faulty();
    test_ref_sweep(1'b0, 50, "restart_ignored");
    test_reset_mid();
    test_back_to_back();
    test_random(6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_truth_table_sweeper
`default_nettype wire
